// File: rtl/hood_mode_controller.sv
// Range-hood master mode sequencer: key-driven FSM with per-mode second timers.
// Optional STANDBY auto-off is compiled in with `define HOOD_AUTO_OFF_EN.
module hood_mode_controller #(
  parameter int TICK_CYCLES = 100_000_000,
  parameter int THIRD_SEC   = 60,
  parameter int WAIT_SEC    = 60,
  parameter int CLEAN_SEC   = 180,
  parameter int IDLE_SEC    = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       power_pulse,
  input  logic       menu_pulse,
  input  logic       lvl1_pulse,
  input  logic       lvl2_pulse,
  input  logic       lvl3_pulse,
  input  logic       clean_pulse,
  output logic [2:0] state,
  output logic [7:0] remain_sec,
  output logic       third_used,
  output logic       clean_done
);

  typedef enum logic [2:0] {
    S_OFF         = 3'b000,
    S_STANDBY     = 3'b001,
    S_MODE_SELECT = 3'b010,
    S_FIRST       = 3'b011,
    S_SECOND      = 3'b100,
    S_THIRD       = 3'b101,
    S_CLEAN       = 3'b110,
    S_WAIT        = 3'b111
  } state_t;

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  state_t        cur, nxt;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [7:0]    remain_q;
  logic [7:0]    load_val;
  logic          third_used_q;
  logic          clean_done_q;
  logic          expire;
  logic          auto_off;

  // Key pulses are single-cycle strobes with no handshake: a pulse is consumed
  // in the cycle it is high, and only the highest-priority key takes effect.
  logic k_power, k_menu, k_clean, k_lvl3, k_lvl2, k_lvl1;
  assign k_power = power_pulse;
  assign k_menu  = menu_pulse  & ~power_pulse;
  assign k_clean = clean_pulse & ~power_pulse & ~menu_pulse;
  assign k_lvl3  = lvl3_pulse  & ~(power_pulse | menu_pulse | clean_pulse);
  assign k_lvl2  = lvl2_pulse  & ~(power_pulse | menu_pulse | clean_pulse | lvl3_pulse);
  assign k_lvl1  = lvl1_pulse  & ~(power_pulse | menu_pulse | clean_pulse | lvl3_pulse |
                                   lvl2_pulse);

  assign tick   = (tick_cnt == TW'(TICK_CYCLES - 1));
  assign expire = tick && (remain_q == 8'd1);

`ifdef HOOD_AUTO_OFF_EN
  logic       any_key;
  logic [7:0] idle_cnt;

  assign any_key  = power_pulse | menu_pulse | clean_pulse |
                    lvl1_pulse | lvl2_pulse | lvl3_pulse;
  assign auto_off = (cur == S_STANDBY) && tick && !any_key &&
                    (idle_cnt == 8'(IDLE_SEC - 1));

  always_ff @(posedge clk) begin
    if (rst || (cur != S_STANDBY) || (nxt != cur) || any_key) begin
      idle_cnt <= 8'd0;
    end else if (tick) begin
      idle_cnt <= idle_cnt + 8'd1;
    end
  end
`else
  logic [7:0] unused_idle_sec;
  assign unused_idle_sec = 8'(IDLE_SEC);
  assign auto_off        = 1'b0;
`endif

  always_comb begin
    nxt = cur;
    if (k_power) begin
      nxt = (cur == S_OFF) ? S_STANDBY : S_OFF;
    end else begin
      case (cur)
        S_OFF: nxt = S_OFF;
        S_STANDBY: begin
          if (k_menu)        nxt = S_MODE_SELECT;
          else if (auto_off) nxt = S_OFF;
        end
        S_MODE_SELECT: begin
          if (k_menu)                        nxt = S_STANDBY;
          else if (k_clean)                  nxt = S_CLEAN;
          else if (k_lvl3 && !third_used_q)  nxt = S_THIRD;
          else if (k_lvl2)                   nxt = S_SECOND;
          else if (k_lvl1)                   nxt = S_FIRST;
        end
        S_FIRST, S_SECOND: begin
          if (k_menu)                        nxt = S_STANDBY;
          else if (k_lvl3 && !third_used_q)  nxt = S_THIRD;
          else if (k_lvl2)                   nxt = S_SECOND;
          else if (k_lvl1)                   nxt = S_FIRST;
        end
        // Menu is checked before expiry so an early exit always wins the race.
        S_THIRD: begin
          if (k_menu)      nxt = S_WAIT;
          else if (expire) nxt = S_SECOND;
        end
        S_WAIT:  if (expire) nxt = S_STANDBY;
        S_CLEAN: if (expire) nxt = S_STANDBY;
        default: nxt = S_OFF;
      endcase
    end
  end

  always_comb begin
    load_val = 8'd0;
    case (nxt)
      S_THIRD: load_val = 8'(THIRD_SEC);
      S_WAIT:  load_val = 8'(WAIT_SEC);
      S_CLEAN: load_val = 8'(CLEAN_SEC);
      default: load_val = 8'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur          <= S_OFF;
      tick_cnt     <= '0;
      remain_q     <= 8'd0;
      third_used_q <= 1'b0;
      clean_done_q <= 1'b0;
    end else begin
      cur          <= nxt;
      clean_done_q <= (cur == S_CLEAN) && (nxt == S_STANDBY);
      // Every state change restarts the second so each timed state gets a full first second.
      if (nxt != cur) begin
        tick_cnt <= '0;
        remain_q <= load_val;
      end else begin
        tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
        if (tick && (remain_q != 8'd0)) remain_q <= remain_q - 8'd1;
      end
      if (nxt == S_OFF)        third_used_q <= 1'b0;
      else if (nxt == S_THIRD) third_used_q <= 1'b1;
    end
  end

  assign state      = cur;
  assign remain_sec = remain_q;
  assign third_used = third_used_q;
  assign clean_done = clean_done_q;

endmodule

// File: tb/tb_hood_mode_controller.sv
// Scoreboarded directed bench for hood_mode_controller (TICK=4, THIRD=3, WAIT=2, CLEAN=5, IDLE=2).
module tb_hood_mode_controller;

  localparam int W = 13;  // {state[2:0], remain_sec[7:0], third_used, clean_done}

`ifdef HOOD_AUTO_OFF_EN
  localparam logic [2:0] AUTO_ST = 3'b000;
`else
  localparam logic [2:0] AUTO_ST = 3'b001;
`endif

  localparam logic [5:0] K_POWER = 6'b100000;
  localparam logic [5:0] K_MENU  = 6'b010000;
  localparam logic [5:0] K_CLEAN = 6'b001000;
  localparam logic [5:0] K_LVL3  = 6'b000100;
  localparam logic [5:0] K_LVL2  = 6'b000010;
  localparam logic [5:0] K_LVL1  = 6'b000001;

  logic       clk, rst;
  logic       power_pulse, menu_pulse, lvl1_pulse, lvl2_pulse, lvl3_pulse, clean_pulse;
  logic [2:0] state;
  logic [7:0] remain_sec;
  logic       third_used, clean_done;

  hood_mode_controller #(
    .TICK_CYCLES(4), .THIRD_SEC(3), .WAIT_SEC(2), .CLEAN_SEC(5), .IDLE_SEC(2)
  ) dut (
    .clk(clk), .rst(rst),
    .power_pulse(power_pulse), .menu_pulse(menu_pulse),
    .lvl1_pulse(lvl1_pulse), .lvl2_pulse(lvl2_pulse), .lvl3_pulse(lvl3_pulse),
    .clean_pulse(clean_pulse),
    .state(state), .remain_sec(remain_sec),
    .third_used(third_used), .clean_done(clean_done)
  );

  // ---------------- clock / reset ----------------
  int unsigned cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int unsigned  exp_cyc_q[$];
  string        name_q[$];
  int checks   = 0;
  int failures = 0;

  always @(negedge clk) begin
    if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
      logic [W-1:0] e, a;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      void'(exp_cyc_q.pop_front());
      a = {state, remain_sec, third_used, clean_done};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s: got state=%b remain=%0d third_used=%b clean_done=%b, expected state=%b remain=%0d third_used=%b clean_done=%b",
                 n, a[12:10], a[9:2], a[1], a[0], e[12:10], e[9:2], e[1], e[0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [5:0] k);
    {power_pulse, menu_pulse, clean_pulse, lvl3_pulse, lvl2_pulse, lvl1_pulse} = k;
    @(posedge clk);
    #1;
    {power_pulse, menu_pulse, clean_pulse, lvl3_pulse, lvl2_pulse, lvl1_pulse} = 6'b0;
  endtask

  task automatic expect_now(input string n, input logic [2:0] st, input logic [7:0] rem,
                            input logic tu, input logic cd);
    exp_q.push_back({st, rem, tu, cd});
    exp_cyc_q.push_back(cyc);
    name_q.push_back(n);
  endtask

  task automatic reset_pulse(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    {power_pulse, menu_pulse, clean_pulse, lvl3_pulse, lvl2_pulse, lvl1_pulse} = 6'b0;
    #1;
    reset_pulse(2);
    expect_now("reset", 3'b000, 8'd0, 1'b0, 1'b0);

    // basic navigation
    pulse(K_POWER); expect_now("power_on", 3'b001, 8'd0, 1'b0, 1'b0);
    pulse(K_LVL1);  expect_now("standby_ignores_lvl1", 3'b001, 8'd0, 1'b0, 1'b0);
    pulse(K_MENU);  expect_now("menu_select", 3'b010, 8'd0, 1'b0, 1'b0);
    pulse(K_LVL2);  expect_now("lvl2", 3'b100, 8'd0, 1'b0, 1'b0);
    pulse(K_LVL1);  expect_now("lvl2_to_lvl1", 3'b011, 8'd0, 1'b0, 1'b0);
    pulse(K_CLEAN); expect_now("first_ignores_clean", 3'b011, 8'd0, 1'b0, 1'b0);
    pulse(K_MENU);  expect_now("first_menu_standby", 3'b001, 8'd0, 1'b0, 1'b0);
    pulse(K_MENU);  expect_now("menu_select2", 3'b010, 8'd0, 1'b0, 1'b0);

    // hurricane run to expiry
    pulse(K_LVL3);  expect_now("third_entry", 3'b101, 8'd3, 1'b1, 1'b0);
    step(4);        expect_now("third_sec2", 3'b101, 8'd2, 1'b1, 1'b0);
    step(7);        expect_now("third_last", 3'b101, 8'd1, 1'b1, 1'b0);
    step(1);        expect_now("third_expire", 3'b100, 8'd0, 1'b1, 1'b0);
    pulse(K_LVL3);  expect_now("third_used_block_lvl", 3'b100, 8'd0, 1'b1, 1'b0);
    pulse(K_MENU);  expect_now("second_menu", 3'b001, 8'd0, 1'b1, 1'b0);
    pulse(K_MENU);  expect_now("menu_select3", 3'b010, 8'd0, 1'b1, 1'b0);
    pulse(K_LVL3);  expect_now("third_used_block_sel", 3'b010, 8'd0, 1'b1, 1'b0);

    // early exit through WAIT_TO_STANDBY
    pulse(K_POWER); expect_now("power_off_clears", 3'b000, 8'd0, 1'b0, 1'b0);
    pulse(K_POWER); expect_now("power_on2", 3'b001, 8'd0, 1'b0, 1'b0);
    pulse(K_MENU);  expect_now("menu_select4", 3'b010, 8'd0, 1'b0, 1'b0);
    pulse(K_LVL3);  expect_now("third_reentry", 3'b101, 8'd3, 1'b1, 1'b0);
    step(4);        expect_now("third_mid", 3'b101, 8'd2, 1'b1, 1'b0);
    pulse(K_MENU);  expect_now("early_exit_wait", 3'b111, 8'd2, 1'b1, 1'b0);
    step(7);        expect_now("wait_last", 3'b111, 8'd1, 1'b1, 1'b0);
    step(1);        expect_now("wait_expire", 3'b001, 8'd0, 1'b1, 1'b0);
    pulse(K_POWER); expect_now("power_off2", 3'b000, 8'd0, 1'b0, 1'b0);
    pulse(K_POWER); pulse(K_MENU);
    pulse(K_LVL3);  expect_now("third_after_cycle", 3'b101, 8'd3, 1'b1, 1'b0);

    // simultaneous keys
    pulse(K_POWER | K_MENU); expect_now("power_beats_menu", 3'b000, 8'd0, 1'b0, 1'b0);
    pulse(K_POWER); pulse(K_MENU);
    pulse(K_LVL3);  expect_now("third_again", 3'b101, 8'd3, 1'b1, 1'b0);
    step(11);       expect_now("third_expiry_cycle", 3'b101, 8'd1, 1'b1, 1'b0);
    pulse(K_MENU);  expect_now("menu_beats_expiry", 3'b111, 8'd2, 1'b1, 1'b0);
    step(7);        expect_now("wait_expiry_cycle", 3'b111, 8'd1, 1'b1, 1'b0);
    pulse(K_POWER); expect_now("power_beats_expiry", 3'b000, 8'd0, 1'b0, 1'b0);
    pulse(K_POWER); pulse(K_MENU);
    pulse(K_LVL1 | K_LVL2);  expect_now("lvl2_beats_lvl1", 3'b100, 8'd0, 1'b0, 1'b0);
    pulse(K_CLEAN | K_LVL3); expect_now("clean_masks_lvl3", 3'b100, 8'd0, 1'b0, 1'b0);
    pulse(K_MENU); pulse(K_MENU);
    pulse(K_MENU | K_LVL1);  expect_now("menu_beats_lvl1", 3'b001, 8'd0, 1'b0, 1'b0);
    pulse(K_MENU);

    // self-clean to completion
    pulse(K_CLEAN); expect_now("clean_entry", 3'b110, 8'd5, 1'b0, 1'b0);
    pulse(K_MENU);  expect_now("clean_ignores_menu", 3'b110, 8'd5, 1'b0, 1'b0);
    step(18);       expect_now("clean_last", 3'b110, 8'd1, 1'b0, 1'b0);
    step(1);        expect_now("clean_done_pulse", 3'b001, 8'd0, 1'b0, 1'b1);
    step(1);        expect_now("clean_done_drop", 3'b001, 8'd0, 1'b0, 1'b0);

    // power mid-clean
    pulse(K_MENU);
    pulse(K_CLEAN); expect_now("clean_entry2", 3'b110, 8'd5, 1'b0, 1'b0);
    step(9);        expect_now("clean_mid", 3'b110, 8'd3, 1'b0, 1'b0);
    pulse(K_POWER); expect_now("clean_power_abort", 3'b000, 8'd0, 1'b0, 1'b0);
    step(1);        expect_now("clean_abort_no_done", 3'b000, 8'd0, 1'b0, 1'b0);

    // reset mid-countdown
    pulse(K_POWER); pulse(K_MENU);
    pulse(K_LVL3);  expect_now("third_before_rst", 3'b101, 8'd3, 1'b1, 1'b0);
    step(2);
    reset_pulse(1); expect_now("rst_mid_count", 3'b000, 8'd0, 1'b0, 1'b0);

    // STANDBY idle behaviour
    pulse(K_POWER); expect_now("idle_start", 3'b001, 8'd0, 1'b0, 1'b0);
    step(7);        expect_now("idle_before", 3'b001, 8'd0, 1'b0, 1'b0);
    step(1);        expect_now("idle_auto_off", AUTO_ST, 8'd0, 1'b0, 1'b0);
`ifndef HOOD_AUTO_OFF_EN
    pulse(K_POWER);
`endif
    pulse(K_POWER); expect_now("idle_start2", 3'b001, 8'd0, 1'b0, 1'b0);
    step(5);
    pulse(K_LVL1);  expect_now("idle_key_ignored", 3'b001, 8'd0, 1'b0, 1'b0);
    step(2);        expect_now("idle_key_clears", 3'b001, 8'd0, 1'b0, 1'b0);
    step(4);        expect_now("idle_auto_off2", AUTO_ST, 8'd0, 1'b0, 1'b0);
`ifndef HOOD_AUTO_OFF_EN
    pulse(K_POWER);
`endif
    pulse(K_POWER);
    step(5);
    pulse(K_MENU);  expect_now("idle_menu", 3'b010, 8'd0, 1'b0, 1'b0);
    step(4);        expect_now("idle_menu_hold", 3'b010, 8'd0, 1'b0, 1'b0);

    // ---------------- report ----------------
    step(2);
    if (exp_q.size() != 0) begin
      failures += exp_q.size();
      $display("FAIL unchecked_entries: got %0d pending, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hood_mode_controller.md
# hood_mode_controller

Master mode sequencer for the range-hood controller. Consumes single-cycle, debounced key pulses and produces the registered 3-bit `state` code that drives `mode_indicator` and the fan/lighting logic. Owns all mode timers:
- third-level (hurricane) run limit
- return-to-standby wait
- self-clean duration

It also exports the remaining seconds for the seven-segment display.

## Interface
Parameters:
- TICK_CYCLES, 100_000_000: clk cycles per one-second tick.
- THIRD_SEC, 60: maximum run time of THIRD_LEVEL, in seconds.
- WAIT_SEC, 60: WAIT_TO_STANDBY countdown, in seconds.
- CLEAN_SEC, 180: SELF_CLEAN duration, in seconds.
- IDLE_SEC, 30: STANDBY auto-off timeout. Used only with HOOD_AUTO_OFF_EN.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- power_pulse  in  1  power key, one-cycle pulse.
- menu_pulse  in  1  menu/return key, one-cycle pulse.
- lvl1_pulse, lvl2_pulse, lvl3_pulse  in  1 each  level keys.
- clean_pulse  in  1  self-clean key.
- state  out  3  mode code:
  - OFF=000, STANDBY=001, MODE_SELECT=010
  - FIRST_LEVEL=011, SECOND_LEVEL=100, THIRD_LEVEL=101
  - SELF_CLEAN=110, WAIT_TO_STANDBY=111
- remain_sec  out  8  seconds left in the current timed state; 0 otherwise.
- third_used  out  1  hurricane already used this power cycle.
- clean_done  out  1  one-cycle pulse when SELF_CLEAN completes.

## Operation
- Reset values: state=OFF, remain_sec=0, third_used=0, clean_done=0. The tick counter also clears.
- Key priority when several keys pulse in the same cycle: power > menu > clean > lvl3 > lvl2 > lvl1. Only the highest-priority key acts.
- power_pulse:
  - From OFF: go to STANDBY.
  - From any other state: go to OFF.
  - Power beats timer expiry in the same cycle.
- STANDBY:
  - menu: go to MODE_SELECT.
  - Other keys are ignored.
- MODE_SELECT:
  - lvl1: go to FIRST_LEVEL. lvl2: go to SECOND_LEVEL.
  - lvl3: go to THIRD_LEVEL only if third_used=0; otherwise ignored.
  - clean: go to SELF_CLEAN.
  - menu: go back to STANDBY.
- FIRST_LEVEL / SECOND_LEVEL:
  - lvl1 and lvl2 switch between the two levels directly.
  - lvl3 follows the same third_used rule as MODE_SELECT.
  - menu: go to STANDBY.
  - clean is ignored.
- THIRD_LEVEL:
  - Entry sets third_used=1 and loads remain_sec=THIRD_SEC.
  - On expiry: go to SECOND_LEVEL.
  - menu: go to WAIT_TO_STANDBY. Menu beats expiry in the same cycle.
  - Level and clean keys are ignored.
- WAIT_TO_STANDBY: entry loads WAIT_SEC; on expiry go to STANDBY. All keys except power are ignored.
- SELF_CLEAN: entry loads CLEAN_SEC; on expiry go to STANDBY and pulse clean_done. All keys except power are ignored.
- third_used clears only on rst or on entry to OFF.
- remain_sec:
  - Decrements on each tick while in a timed state.
  - The tick at which remain_sec=1 is the expiry; the next state has remain_sec=0, or the new load value if that state is timed.
- Width rule: all durations must be ≤255. Parameters >255 are illegal; no saturation logic.

## Timing
- A key pulse in cycle N changes state, remain_sec and third_used in cycle N+1. The block is fully registered: no combinational path from input to output.
- Tick counter runs 0..TICK_CYCLES-1 and restarts at 0 on every state change. The first second of each timed state is therefore a full TICK_CYCLES long.
- Expiry latency: entering a timed state with duration D at cycle N leaves that state at cycle N + D·TICK_CYCLES.
- clean_done is high in exactly the first cycle of the STANDBY that follows SELF_CLEAN.
- rst asserted mid-countdown: state=OFF in the next cycle, timers abandoned, no clean_done.

## Configuration
- Macro: HOOD_AUTO_OFF_EN.
- Defined:
  - While in STANDBY, an internal idle counter counts ticks and clears on any key pulse.
  - After IDLE_SEC seconds with no key, state goes to OFF, following the normal OFF entry rules.
  - remain_sec stays 0 in STANDBY.
- Undefined: STANDBY persists indefinitely; no idle counter is synthesized.

## Test plan
Bench parameters: TICK_CYCLES=4, THIRD_SEC=3, WAIT_SEC=2, CLEAN_SEC=5, IDLE_SEC=2.
- Reset then power: rst high 2 cycles -> state=000, remain_sec=0. power_pulse -> state=001 next cycle. menu -> 010. lvl2 -> 100. lvl1 -> 011.
- Hurricane: from MODE_SELECT lvl3 -> state=101, remain_sec=3, third_used=1. After 12 cycles -> state=100. Then lvl3 -> state stays 100.
- Early exit: in THIRD_LEVEL, menu after 5 cycles -> state=111, remain_sec=2. After 8 cycles -> state=001. Power -> 000, third_used=0. Power again, then lvl3 from MODE_SELECT is accepted.
- Self-clean: from MODE_SELECT clean -> state=110, remain_sec=5. After 20 cycles -> state=001 with clean_done high exactly 1 cycle. power_pulse mid-clean -> 000, no clean_done.
- Simultaneous keys: power+menu in THIRD_LEVEL -> 000. menu on the expiry cycle -> 111. lvl1+lvl2 in MODE_SELECT -> 100.
- HOOD_AUTO_OFF_EN: STANDBY with no keys -> 000 after 8 cycles. A menu pulse at cycle 6 -> 010, no auto-off.
